wb_stage: RTL and testbench
===========================

# wb_stage

Write-back stage of the NPC pipeline, directly upstream of the commit/DPI block. Accepts one retiring instruction per cycle from the memory stage over a valid/ready handshake and holds it in a single-entry register. In the following cycle it writes the register file, presents a one-cycle commit record (pc, ebreak, mmio) to the commit block, and drives a forwarding port. It halts intake on ebreak and keeps a 64-bit retired-instruction counter.

## Interface
Parameters:
- XLEN, 32: data and pc width.
- RAW, 5: register address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  memory stage has an instruction to retire.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  XLEN  pc of the instruction.
- in_rf_wen  in  1  instruction writes rd.
- in_rd  in  RAW  destination register.
- in_wdata  in  XLEN  write-back data.
- in_ebreak  in  1  instruction is ebreak.
- in_is_mmio  in  1  instruction accessed MMIO (difftest skip).
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  RAW  register-file write address.
- rf_wdata  out  XLEN  register-file write data.
- fwd_valid  out  1  forwarding entry is valid (equals rf_wen).
- fwd_rd  out  RAW  forwarded register.
- fwd_data  out  XLEN  forwarded value.
- commit_valid  out  1  one instruction retires this cycle.
- commit_pc  out  XLEN  pc of the retiring instruction.
- commit_ebreak  out  1  retiring instruction is ebreak.
- commit_is_mmio  out  1  retiring instruction was MMIO.
- halted  out  1  ebreak has retired; intake stopped.
- instret  out  64  count of retired instructions.

## Operation
- Entry register fields: wb_valid, pc, rf_wen, rd, wdata, ebreak, is_mmio. State machine: RUN, HALT.
- in_ready = !rst && state==RUN && !(wb_valid && wb_ebreak). The stage never back-pressures in RUN except for the ebreak cycle.
- Accept means in_valid && in_ready. On accept, all fields load and wb_valid is set to 1. Without an accept, wb_valid is cleared to 0, so every entry lives exactly one cycle.
- rf_wen = wb_valid && wb_rf_wen && (wb_rd != 0) && !wb_ebreak. Writes to x0 and ebreak entries are suppressed.
- rf_waddr/rf_wdata and fwd_rd/fwd_data come straight from the entry register. fwd_valid = rf_wen.
- commit_valid = wb_valid. commit_pc, commit_ebreak and commit_is_mmio mirror the entry and are forced to 0 when wb_valid is 0.
- instret increments by 1 on every cycle with commit_valid=1. It wraps from 2^64-1 to 0.
- RUN→HALT on the edge that ends a cycle with wb_valid && wb_ebreak. HALT is sticky until rst. In HALT: in_ready=0, wb_valid stays 0, instret is frozen.
- halted = (state==HALT).

## Timing
- Reset (asynchronous, immediate): state=RUN, wb_valid=0, all entry fields 0, instret=0. Every output reads 0, including in_ready.
- Latency: accepted at edge N → rf write, commit and forward all visible during cycle N+1. The regfile write takes effect at edge N+1.
- Back-to-back: accepts on consecutive edges give commit_valid=1 on consecutive cycles with no bubble.
- Ebreak accepted at edge N:
  - Cycle N+1: commit_valid=1, commit_ebreak=1, in_ready=0.
  - Edge N+1: state becomes HALT.
  - Cycle N+2 onward: halted=1.
- An in_valid held high during the halt is never accepted. No instruction after the ebreak retires.
- Reset asserted mid-operation discards the entry with no commit and no rf write. After deassertion, in_ready=1 in the first cycle.
- in_* signals are sampled only on accept edges. Their value is don't-care otherwise.

## Test plan
- Reset, then a single accept of pc=0x80000000, rd=5, wdata=0xDEADBEEF, rf_wen=1 → next cycle: rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF, commit_valid=1, commit_pc=0x80000000; instret=1 the cycle after.
- 8 consecutive accepts (pc 0x80000000 + 4k) → commit_valid high 8 consecutive cycles with the matching pcs, then low; instret=8.
- Accept with rd=0, rf_wen=1, wdata=0x1234 → commit_valid=1, rf_wen=0, fwd_valid=0.
- Accept of an MMIO load (is_mmio=1, pc=0x80000010), then an ebreak at pc=0x80000014, with in_valid held high after → commit_is_mmio=1 for the first; commit_ebreak=1 with in_ready=0 that cycle; halted=1 next cycle; no further commits; instret=2 and frozen.
- Assert rst mid-stream, one cycle after an accept → commit_valid drops immediately, no rf write, instret=0, halted=0; in_ready=1 after deassertion.
- Preload instret near wrap via a forced value of 2^64-1, then one commit → instret=0.

Source files
------------

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_stage
// Purpose  : Write-back stage of the NPC pipeline. Holds one retiring
//            instruction for exactly one cycle. During that cycle it writes
//            the register file, presents a commit record and drives the
//            forwarding port. Stops intake once an ebreak retires. Counts
//            retired instructions in a 64-bit counter.
// Ports    : clk, rst (async, active-high)
//            in_*     : valid/ready retire handshake from the memory stage
//            rf_*     : register-file write port
//            fwd_*    : forwarding port (fwd_valid == rf_wen)
//            commit_* : one-cycle commit record for the commit/DPI block
//            halted   : ebreak has retired
//            instret  : retired-instruction count (wraps at 2^64)
// Revision : 1.0 - initial release
// ============================================================================
module wb_stage #(
  parameter int XLEN = 32,
  parameter int RAW  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic              in_rf_wen,
  input  logic [RAW-1:0]    in_rd,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic              in_ebreak,
  input  logic              in_is_mmio,
  output logic              rf_wen,
  output logic [RAW-1:0]    rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              fwd_valid,
  output logic [RAW-1:0]    fwd_rd,
  output logic [XLEN-1:0]   fwd_data,
  output logic              commit_valid,
  output logic [XLEN-1:0]   commit_pc,
  output logic              commit_ebreak,
  output logic              commit_is_mmio,
  output logic              halted,
  output logic [63:0]       instret
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      state;
  logic [0:0]      state_next;

  // Single-entry write-back register
  logic            wb_valid;
  logic [XLEN-1:0] wb_pc;
  logic            wb_rf_wen;
  logic [RAW-1:0]  wb_rd;
  logic [XLEN-1:0] wb_wdata;
  logic            wb_ebreak;
  logic            wb_is_mmio;

  logic [63:0]     instret_cnt;
  logic            accept;
  logic            ebreak_retire;

  assign ebreak_retire = wb_valid && wb_ebreak;
  assign accept        = in_valid && in_ready;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:  if (ebreak_retire) state_next = ST_HALT;
      ST_HALT: state_next = ST_HALT;   // sticky until reset
      default: state_next = ST_RUN;
    endcase
  end

  // The ebreak cycle itself already refuses intake so nothing slips in
  // behind it on the edge that moves the FSM to HALT.
  always_comb begin
    in_ready = 1'b0;
    halted   = 1'b0;
    case (state)
      ST_RUN:  in_ready = !rst && !ebreak_retire;
      ST_HALT: halted   = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  // ------------------------------------------------------- entry register
  // wb_valid follows accept every edge, so an entry lives exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_pc      <= '0;
      wb_rf_wen  <= 1'b0;
      wb_rd      <= '0;
      wb_wdata   <= '0;
      wb_ebreak  <= 1'b0;
      wb_is_mmio <= 1'b0;
    end else begin
      wb_valid <= accept;
      if (accept) begin
        wb_pc      <= in_pc;
        wb_rf_wen  <= in_rf_wen;
        wb_rd      <= in_rd;
        wb_wdata   <= in_wdata;
        wb_ebreak  <= in_ebreak;
        wb_is_mmio <= in_is_mmio;
      end
    end
  end

  // ------------------------------------------------------ retire counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instret_cnt <= '0;
    end else if (wb_valid) begin
      instret_cnt <= instret_cnt + 64'd1;
    end
  end

  // ------------------------------------------------------------- outputs
  // x0 writes and ebreak entries never reach the register file.
  assign rf_wen   = wb_valid && wb_rf_wen && (wb_rd != '0) && !wb_ebreak;
  assign rf_waddr = wb_rd;
  assign rf_wdata = wb_wdata;

  assign fwd_valid = rf_wen;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_wdata;

  assign commit_valid   = wb_valid;
  assign commit_pc      = wb_valid ? wb_pc : '0;
  assign commit_ebreak  = wb_valid && wb_ebreak;
  assign commit_is_mmio = wb_valid && wb_is_mmio;

  assign instret = instret_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_stage
// Purpose  : Self-checking bench for wb_stage. A transaction-level model
//            (last accepted instruction, halted flag, retire count) predicts
//            every output each cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam int XLEN = 32;
  localparam int RAW  = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [XLEN-1:0] in_pc = '0;
  logic            in_rf_wen = 1'b0;
  logic [RAW-1:0]  in_rd = '0;
  logic [XLEN-1:0] in_wdata = '0;
  logic            in_ebreak = 1'b0;
  logic            in_is_mmio = 1'b0;
  logic            rf_wen;
  logic [RAW-1:0]  rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            fwd_valid;
  logic [RAW-1:0]  fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic            commit_ebreak;
  logic            commit_is_mmio;
  logic            halted;
  logic [63:0]     instret;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_rf_wen(in_rf_wen), .in_rd(in_rd), .in_wdata(in_wdata),
    .in_ebreak(in_ebreak), .in_is_mmio(in_is_mmio),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_ebreak(commit_ebreak), .commit_is_mmio(commit_is_mmio),
    .halted(halted), .instret(instret)
  );

  // ------------------------------------------------------------ model
  // "held" is the instruction retiring this cycle (if any).
  logic            m_valid = 1'b0;
  logic [XLEN-1:0] m_pc = '0;
  logic            m_rfw = 1'b0;
  logic [RAW-1:0]  m_rd = '0;
  logic [XLEN-1:0] m_wdata = '0;
  logic            m_ebreak = 1'b0;
  logic            m_mmio = 1'b0;
  logic            m_halted = 1'b0;
  logic [63:0]     m_instret = '0;
  logic            preload_req = 1'b0;
  logic            skip_cmp = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit can_take;
    if (rst) begin
      m_valid = 0; m_pc = '0; m_rfw = 0; m_rd = '0; m_wdata = '0;
      m_ebreak = 0; m_mmio = 0; m_halted = 0; m_instret = '0;
    end else begin
      if (preload_req) m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      can_take = !m_halted && !(m_valid && m_ebreak);
      if (m_valid) m_instret = m_instret + 64'd1;
      if (m_valid && m_ebreak) m_halted = 1'b1;
      m_valid = in_valid && can_take;
      if (m_valid) begin
        m_pc = in_pc; m_rfw = in_rf_wen; m_rd = in_rd; m_wdata = in_wdata;
        m_ebreak = in_ebreak; m_mmio = in_is_mmio;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic e_ready, e_wen;
    e_ready = !rst && !m_halted && !(m_valid && m_ebreak);
    e_wen   = m_valid && m_rfw && (m_rd != 0) && !m_ebreak;
    chk("in_ready", {63'd0, in_ready}, {63'd0, e_ready});
    chk("rf_wen", {63'd0, rf_wen}, {63'd0, e_wen});
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e_wen});
    if (e_wen) begin
      chk("rf_waddr", 64'(rf_waddr), 64'(m_rd));
      chk("rf_wdata", 64'(rf_wdata), 64'(m_wdata));
      chk("fwd_rd", 64'(fwd_rd), 64'(m_rd));
      chk("fwd_data", 64'(fwd_data), 64'(m_wdata));
    end
    chk("commit_valid", {63'd0, commit_valid}, {63'd0, m_valid});
    chk("commit_pc", 64'(commit_pc), m_valid ? 64'(m_pc) : 64'd0);
    chk("commit_ebreak", {63'd0, commit_ebreak}, {63'd0, m_valid && m_ebreak});
    chk("commit_is_mmio", {63'd0, commit_is_mmio}, {63'd0, m_valid && m_mmio});
    chk("halted", {63'd0, halted}, {63'd0, m_halted});
    chk("instret", instret, m_instret);
  endtask

  // Compare at the falling edge, then return just after the next rising edge
  // so stimulus changes stay clear of the active edge.
  task automatic step();
    @(negedge clk);
    if (!skip_cmp) compare_all();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic wen,
                       input logic [RAW-1:0] rd, input logic [XLEN-1:0] wd,
                       input logic eb, input logic mm);
    in_valid = v; in_pc = pc; in_rf_wen = wen; in_rd = rd;
    in_wdata = wd; in_ebreak = eb; in_is_mmio = mm;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    // ---- reset state
    #2;
    chk("reset in_ready", {63'd0, in_ready}, 64'd0);
    chk("reset commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("reset instret", instret, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {63'd0, in_ready}, 64'd1);

    // ---- single accept
    drive(1, 32'h8000_0000, 1, 5'd5, 32'hDEAD_BEEF, 0, 0);
    step();
    in_valid = 1'b0;
    chk("t1 rf_wen", {63'd0, rf_wen}, 64'd1);
    chk("t1 rf_waddr", 64'(rf_waddr), 64'd5);
    chk("t1 rf_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    chk("t1 commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("t1 commit_pc", 64'(commit_pc), 64'h8000_0000);
    step();
    chk("t1 instret", instret, 64'd1);

    // ---- eight back-to-back accepts
    reset_pulse();
    for (int k = 0; k < 8; k++) begin
      drive(1, 32'h8000_0000 + 32'(4 * k), 1, 5'(k + 1), 32'(k * 7), 0, 0);
      step();
      chk("b2b commit_valid", {63'd0, commit_valid}, 64'd1);
      chk("b2b commit_pc", 64'(commit_pc), 64'h8000_0000 + 64'(4 * k));
    end
    in_valid = 1'b0;
    step();
    chk("b2b drain commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("b2b instret", instret, 64'd8);

    // ---- write to x0 suppressed
    drive(1, 32'h8000_0100, 1, 5'd0, 32'h1234, 0, 0);
    step();
    in_valid = 1'b0;
    chk("x0 commit_valid", {63'd0, commit_valid}, 64'd1);
    chk("x0 rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("x0 fwd_valid", {63'd0, fwd_valid}, 64'd0);
    step();

    // ---- randomized stream; recover from halts with a reset
    for (int c = 0; c < 400; c++) begin
      if (m_halted) begin
        reset_pulse();
      end else begin
        drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1,
              ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
              $urandom, $urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0);
        step();
      end
    end

    // ---- reset asserted one cycle after an accept
    reset_pulse();
    drive(1, 32'h8000_0200, 1, 5'd3, 32'h5555, 0, 0);
    step();
    step();
    #1;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("midrst rf_wen", {63'd0, rf_wen}, 64'd0);
    chk("midrst in_ready", {63'd0, in_ready}, 64'd0);
    chk("midrst instret", instret, 64'd0);
    chk("midrst halted", {63'd0, halted}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("midrst in_ready after", {63'd0, in_ready}, 64'd1);
    step();

    // ---- instret wrap from 2^64-1
    in_valid = 1'b0;
    step();
    skip_cmp = 1'b1;
    preload_req = 1'b1;
    force dut.instret_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    release dut.instret_cnt;
    preload_req = 1'b0;
    skip_cmp = 1'b0;
    #1;
    chk("wrap preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1, 32'h8000_0300, 0, 5'd1, 32'h0, 0, 0);
    step();
    in_valid = 1'b0;
    step();
    chk("wrap instret", instret, 64'd0);

    // ---- MMIO load then ebreak with in_valid held high
    reset_pulse();
    drive(1, 32'h8000_0010, 1, 5'd7, 32'hA5A5, 0, 1);
    step();
    chk("mmio commit_is_mmio", {63'd0, commit_is_mmio}, 64'd1);
    chk("mmio commit_pc", 64'(commit_pc), 64'h8000_0010);
    drive(1, 32'h8000_0014, 0, 5'd0, 32'h0, 1, 0);
    step();
    chk("ebreak commit_ebreak", {63'd0, commit_ebreak}, 64'd1);
    chk("ebreak commit_pc", 64'(commit_pc), 64'h8000_0014);
    chk("ebreak in_ready", {63'd0, in_ready}, 64'd0);
    drive(1, 32'h8000_0018, 1, 5'd9, 32'h77, 0, 0);
    step();
    chk("halt halted", {63'd0, halted}, 64'd1);
    chk("halt commit_valid", {63'd0, commit_valid}, 64'd0);
    chk("halt instret", instret, 64'd2);
    for (int k = 0; k < 4; k++) step();
    chk("halt frozen instret", instret, 64'd2);
    chk("halt no commit", {63'd0, commit_valid}, 64'd0);
    chk("halt in_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
